// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI byte engine.
// The SPI_AUTO_READ_EN build option is handled in spi_byte_engine.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_FIN  = 2'd3
  } spi_state_t;

  localparam logic [1:0] SS_NONE  = 2'b11;
  localparam logic [7:0] FILL_DEF = 8'hFF;
  localparam int         CNT_W    = 3;

  // MISO[2] is the fallback line when no slave select is active.
  function automatic logic misox_sel(
    input logic [2:0] miso,
    input logic [1:0] nss
  );
    return (miso[0] & ~nss[0]) |
           (miso[1] & ~nss[1]) |
           (miso[2] & nss[0] & nss[1]);
  endfunction

endpackage

// File: rtl/spi_tick_div.sv
// Half-period tick generator: o_tick is high every DIV cycles,
// restarting from zero on a synchronous clear.
module spi_tick_div #(
  parameter int DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] r_cnt;

  assign o_tick = (r_cnt == W'(DIV - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_byte_engine.sv
// SPI mode-0 byte shifter, MSB first, with MISO capture and status flags.
// Build option SPI_AUTO_READ_EN: an idle RD_STB starts a FILL transfer.
module spi_byte_engine
  import spi_pkg::*;
#(
  parameter int         DIV  = 2,
  parameter logic [7:0] FILL = FILL_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       WR_STB,
  input  logic [7:0] WR_DATA,
  input  logic       SS_WR,
  input  logic [1:0] SS_DATA,
  input  logic       RD_STB,
  input  logic [2:0] MISO,
  output logic       MOSI,
  output logic       SCK,
  output logic [1:0] nSS,
  output logic [7:0] RD_DATA,
  output logic       BUSY,
  output logic       DONE,
  output logic       OVR
);

  spi_state_t       r_state;
  spi_state_t       w_next;
  logic [7:0]       r_shreg;
  logic [7:0]       r_rxreg;
  logic [CNT_W-1:0] r_cnt;
  logic             w_tick;
  logic             w_idle;
  logic             w_start;
  logic             w_misox;
  logic [7:0]       w_load;

  assign w_idle  = (r_state == ST_IDLE);
  assign w_misox = misox_sel(MISO, nSS);
  assign w_load  = WR_STB ? WR_DATA : FILL;

`ifdef SPI_AUTO_READ_EN
  assign w_start = w_idle & (WR_STB | RD_STB);
`else
  assign w_start = w_idle & WR_STB;
`endif

  assign BUSY = ~w_idle;
  assign DONE = (r_state == ST_FIN);

  spi_tick_div #(
    .DIV (DIV)
  ) u_div (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_clr  (w_start),
    .o_tick (w_tick)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_start) w_next = ST_LOW;
      ST_LOW:  if (w_tick)  w_next = ST_HIGH;
      ST_HIGH: begin
        if (w_tick) begin
          w_next = (&r_cnt) ? ST_FIN : ST_LOW;
        end
      end
      ST_FIN:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      SCK     <= 1'b0;
      MOSI    <= 1'b1;
      nSS     <= SS_NONE;
      RD_DATA <= 8'h00;
      OVR     <= 1'b0;
      r_shreg <= 8'h00;
      r_rxreg <= 8'h00;
      r_cnt   <= '0;
    end else begin
      if (SS_WR) nSS <= SS_DATA;

      // A rejected write wins over a coincident clearing read.
      if (WR_STB && !w_idle) begin
        OVR <= 1'b1;
      end else if (RD_STB) begin
        OVR <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_shreg <= w_load;
            MOSI    <= w_load[7];
            r_cnt   <= '0;
          end
        end
        ST_LOW: begin
          if (w_tick) begin
            SCK     <= 1'b1;
            r_rxreg <= {r_rxreg[6:0], w_misox};
          end
        end
        ST_HIGH: begin
          if (w_tick) begin
            SCK   <= 1'b0;
            r_cnt <= r_cnt + 1'b1;
            if (&r_cnt) begin
              RD_DATA <= r_rxreg;
            end else begin
              r_shreg <= {r_shreg[6:0], 1'b0};
              MOSI    <= r_shreg[6];
            end
          end
        end
        ST_FIN: MOSI <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_byte_engine.sv
// Directed bench: a DIV=1 and a DIV=2 engine share strobes and run
// side by side; each one loops MISO[0] from its own MOSI when lb is set.
module tb_spi_byte_engine;

  logic       CLK;
  logic       RST;
  logic       wr;
  logic [7:0] wdata;
  logic       ss_wr;
  logic [1:0] ss_data;
  logic       rd;
  logic [2:0] m;
  logic       lb;

  logic       mosi1, sck1, busy1, done1, ovr1;
  logic [1:0] nss1;
  logic [7:0] rdd1;
  logic       mosi2, sck2, busy2, done2, ovr2;
  logic [1:0] nss2;
  logic [7:0] rdd2;
  logic [2:0] miso1, miso2;

  assign miso1 = {m[2], m[1], lb ? mosi1 : m[0]};
  assign miso2 = {m[2], m[1], lb ? mosi2 : m[0]};

  spi_byte_engine #(.DIV(1)) u_dut1 (
    .CLK(CLK), .RST(RST), .WR_STB(wr), .WR_DATA(wdata),
    .SS_WR(ss_wr), .SS_DATA(ss_data), .RD_STB(rd), .MISO(miso1),
    .MOSI(mosi1), .SCK(sck1), .nSS(nss1), .RD_DATA(rdd1),
    .BUSY(busy1), .DONE(done1), .OVR(ovr1)
  );

  spi_byte_engine #(.DIV(2)) u_dut2 (
    .CLK(CLK), .RST(RST), .WR_STB(wr), .WR_DATA(wdata),
    .SS_WR(ss_wr), .SS_DATA(ss_data), .RD_STB(rd), .MISO(miso2),
    .MOSI(mosi2), .SCK(sck2), .nSS(nss2), .RD_DATA(rdd2),
    .BUSY(busy2), .DONE(done2), .OVR(ovr2)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] bits1, bits2;
  int         rise1, rise2, dk1, dk2, nd1, nd2, nbusy2;
  logic       bk1, bk2;

  task automatic ss_pulse(input logic [1:0] v);
    @(posedge CLK); #1;
    ss_wr = 1'b1;
    ss_data = v;
    @(posedge CLK); #1;
    ss_wr = 1'b0;
  endtask

  // Start on WR (or RD), watch 40 cycles; optional extra strobe at
  // cycle xk and optional reset at the rst_rise-th SCK rise of dut2.
  task automatic run(input bit use_rd, input logic [7:0] d,
                     input int xk, input bit x_rd, input int rst_rise);
    logic p1, p2;
    bit   did_rst;
    p1 = 1'b0; p2 = 1'b0; did_rst = 1'b0;
    bits1 = 8'h00; bits2 = 8'h00;
    rise1 = 0; rise2 = 0; dk1 = 0; dk2 = 0;
    nd1 = 0; nd2 = 0; nbusy2 = 0; bk1 = 1'b0; bk2 = 1'b0;
    @(posedge CLK); #1;
    wdata = d;
    if (use_rd) rd = 1'b1;
    else wr = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge CLK); #1;
      wr = 1'b0;
      rd = 1'b0;
      if (RST) RST = 1'b0;
      if (k == xk) begin
        wr = 1'b1;
        rd = x_rd;
        wdata = 8'hFF;
      end
      @(negedge CLK);
      if (sck1 && !p1) begin
        rise1++;
        bits1 = {bits1[6:0], mosi1};
      end
      if (sck2 && !p2) begin
        rise2++;
        bits2 = {bits2[6:0], mosi2};
      end
      if (k == 1) begin
        bk1 = busy1;
        bk2 = busy2;
      end
      if (busy2) nbusy2++;
      if (done1) begin nd1++; dk1 = k; end
      if (done2) begin nd2++; dk2 = k; end
      if (rst_rise != 0 && rise2 == rst_rise && !did_rst) begin
        did_rst = 1'b1;
        RST = 1'b1;
        #1;
        chk("rst_mid_sck", sck2, 0);
        chk("rst_mid_mosi", mosi2, 1);
        chk("rst_mid_nss", nss2, 2'b11);
        chk("rst_mid_rdata", rdd2, 8'h00);
        chk("rst_mid_busy", busy2, 0);
        chk("rst_mid_busy1", busy1, 0);
      end
      p1 = sck1;
      p2 = sck2;
    end
  endtask

  initial begin
    RST = 1'b1;
    wr = 1'b0; wdata = 8'h00; ss_wr = 1'b0; ss_data = 2'b11;
    rd = 1'b0; m = 3'b000; lb = 1'b0;

    // 1: reset state
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_sck", sck1, 0);
    chk("rst_mosi", mosi1, 1);
    chk("rst_nss", nss1, 2'b11);
    chk("rst_rdata", rdd1, 8'h00);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_ovr", ovr1, 0);
    chk("rst_mosi2", mosi2, 1);

    // 2: loopback A5
    ss_pulse(2'b10);
    lb = 1'b1;
    run(1'b0, 8'hA5, 0, 1'b0, 0);
    chk("a5_rises1", rise1, 8);
    chk("a5_mosi1", bits1, 8'hA5);
    chk("a5_done_cyc1", dk1, 17);
    chk("a5_ndone1", nd1, 1);
    chk("a5_busy_k1", bk1, 1);
    chk("a5_rdata1", rdd1, 8'hA5);
    chk("a5_idle1", busy1, 0);
    chk("a5_mosi2", bits2, 8'hA5);
    chk("a5_done_cyc2", dk2, 33);
    chk("a5_rdata2", rdd2, 8'hA5);

    // 3: write while busy, coincident read
    lb = 1'b0;
    run(1'b0, 8'h3C, 5, 1'b1, 0);
    chk("ovr_mosi2", bits2, 8'h3C);
    chk("ovr_rises2", rise2, 8);
    chk("ovr_done_cyc2", dk2, 33);
    chk("ovr_flag2", ovr2, 1);
    chk("ovr_flag1", ovr1, 1);
    chk("ovr_mosi1", bits1, 8'h3C);
    @(posedge CLK); #1 rd = 1'b1;
    @(posedge CLK); #1 rd = 1'b0;
    @(negedge CLK);
    chk("ovr_clr2", ovr2, 0);
    chk("ovr_clr1", ovr1, 0);
    repeat (40) @(posedge CLK);

    // 4: MISO select
    m = 3'b100;
    ss_pulse(2'b01);
    run(1'b0, 8'h00, 0, 1'b0, 0);
    chk("sel01_rdata2", rdd2, 8'h00);
    chk("sel01_rdata1", rdd1, 8'h00);
    ss_pulse(2'b11);
    run(1'b0, 8'h00, 0, 1'b0, 0);
    chk("sel11_rdata2", rdd2, 8'hFF);
    chk("sel11_rdata1", rdd1, 8'hFF);

    // 5: reset at SCK rise 4, then a clean transfer
    run(1'b0, 8'h00, 0, 1'b0, 4);
    chk("rst_rises2", rise2, 4);
    chk("rst_ndone2", nd2, 0);
    chk("rst_ndone1", nd1, 0);
    ss_pulse(2'b10);
    lb = 1'b1;
    run(1'b0, 8'h81, 0, 1'b0, 0);
    chk("post_mosi2", bits2, 8'h81);
    chk("post_done_cyc2", dk2, 33);
    chk("post_rdata2", rdd2, 8'h81);
    chk("post_rdata1", rdd1, 8'h81);

    // 6: idle read
    lb = 1'b0;
    m = 3'b001;
    run(1'b1, 8'h00, 0, 1'b0, 0);
`ifdef SPI_AUTO_READ_EN
    chk("auto_mosi2", bits2, 8'hFF);
    chk("auto_rises2", rise2, 8);
    chk("auto_done_cyc2", dk2, 33);
    chk("auto_rdata2", rdd2, 8'hFF);
    chk("auto_rdata1", rdd1, 8'hFF);
`else
    chk("noauto_busy2", nbusy2, 0);
    chk("noauto_ndone2", nd2, 0);
    chk("noauto_rises2", rise2, 0);
    chk("noauto_rdata2", rdd2, 8'h81);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
